vdma_cfg_sequencer: RTL and testbench
=====================================

// Module: vdma_cfg_sequencer
// PURPOSE
//  AXI4-Lite master on ps_clk that brings up the MM2S channel of the video DMA feeding rgb2dvi.
//  Sequence: soft-reset, wait for reset done, program geometry and frame buffers, run, then poll
//  status. On any DMA error it recovers by reset and reprogram. Sits between PS GP port and VDMA.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32            AXI4-Lite address width
//  C_M_AXI_DATA_WIDTH  32            AXI4-Lite data width (only 32 supported)
//  VDMA_BASEADDR       32'h4300_0000 VDMA register base
//  FB_BASEADDR         32'h1000_0000 frame buffer 0 address
//  VID_H_ACTIVE        1280          pixels per line
//  VID_V_ACTIVE        720           lines per frame
//  BYTES_PER_PIXEL     3             HSIZE = STRIDE = VID_H_ACTIVE*BYTES_PER_PIXEL
//  NUM_FRAMES          3             frame stores, 1..8; START_ADDRn = FB_BASEADDR + n*HSIZE*VSIZE
//  POLL_INTERVAL       1024          ps_clk cycles between DMASR reads in RUN (>=16)
//  TIMEOUT_CYCLES      4096          per-transaction watchdog (VDMA_TIMEOUT_EN only)
// PORTS
//  ps_clk        in   1   system clock
//  rst           in   1   synchronous active-high reset
//  start         in   1   pulse: begin bring-up from IDLE; ignored elsewhere
//  stop          in   1   pulse: halt DMA; latched if not in RUN
//  m_axi_aw*     out  A+1 awaddr[A-1:0], awvalid; awready in 1
//  m_axi_w*      out  37  wdata[31:0], wstrb[3:0] (always 4'hF), wvalid; wready in 1
//  m_axi_b*      -    -   bresp in 2, bvalid in 1, bready out 1
//  m_axi_ar*     out  A+1 araddr, arvalid; arready in 1
//  m_axi_r*      -    -   rdata in 32, rresp in 2, rvalid in 1, rready out 1
//  busy          out  1   high in every state except IDLE and RUN
//  running       out  1   high in RUN
//  dma_error     out  1   sticky until next start; set on DMASR error, bad resp or timeout
//  err_count     out  8   recoveries performed, saturates at 255, cleared by start
// BEHAVIOUR
//  - Reset: all valids, ready outputs, busy, running, dma_error = 0; err_count = 0; FSM = IDLE.
//    rst mid-transaction drops valids next edge; interconnect shares rst.
//  - Bus engine: one outstanding transaction. Writes assert AW and W in the same cycle; each
//    valid drops on its own handshake; bready = 1 until bvalid. Reads: arvalid until arready,
//    then rready = 1 until rvalid. Valids never depend combinationally on ready.
//    Resp != 2'b00 is treated as an error.
//  - FSM:
//    IDLE   -start->           SRST
//    SRST   write DMACR=0x4    -> WAITR
//    WAITR  read DMACR until bit2 = 0 -> CFG
//    CFG    write table in order: DMACR=0x0000_0003 (run, circular), START_ADDR1..NUM_FRAMES,
//           FRMDLY_STRIDE=HSIZE, HSIZE, VSIZE (VSIZE last, this arms the DMA) -> RUN
//    RUN    every POLL_INTERVAL read DMASR; (DMASR & ERR_MASK) != 0 -> ERR; pending stop -> HALT
//    ERR    write DMASR=ERR_MASK (W1C), err_count++, dma_error = 1 -> SRST
//    HALT   write DMACR=0      -> IDLE
//  - Offsets: DMACR 0x00, DMASR 0x04, VSIZE 0x50, HSIZE 0x54, FRMDLY_STRIDE 0x58,
//    START_ADDR1 0x5C + 4*n. Address arithmetic is 32-bit; frame offset is unsigned modulo 2^32.
//  - stop is latched in any non-IDLE state and acted on only from RUN, after the current
//    transaction completes. start and stop in the same cycle in IDLE: start wins, stop is latched.
//  - Bad bresp/rresp in any state -> ERR. An error found during ERR itself -> SRST with no
//    second increment.
// CONFIGURATION
//  VDMA_TIMEOUT_EN defined: watchdog counts cycles a transaction stays open; on TIMEOUT_CYCLES it
//    aborts (drops valids and readies), sets dma_error, goes to SRST. A late bvalid/rvalid is
//    discarded.
//  VDMA_TIMEOUT_EN undefined: no watchdog; the engine waits indefinitely.
// STRUCTURE
//  vdma_cfg_pkg: state enum, register offset localparams, DMACR_RUN/DMACR_RESET, ERR_MASK=0x0000_4FF0.
//  Sub-module axil_single_master: one-shot read/write engine (req, we, addr, wdata -> done,
//  rdata, err); it owns the watchdog. Table index and FSM live in the top.
// TESTING
//  1 start, zero-wait slave -> writes in order: 0x00=4; then reads 0x00 until 0; then 0x00=3,
//    0x5C=0x1000_0000, 0x60=0x102A_3000, 0x64=0x1054_6000, 0x58=0xF00, 0x54=0xF00, 0x50=0x2D0;
//    running=1.
//  2 Random awready/wready skew 0..5 cycles -> each address and data accepted exactly once;
//    order unchanged.
//  3 In RUN, slave DMASR returns 0x0000_0010 -> write 0x04=0x4FF0; err_count=1; dma_error=1;
//    full reprogram; RUN again.
//  4 bresp=2'b10 on HSIZE write -> ERR, then SRST; start afterwards clears err_count to 0.
//  5 stop during CFG -> table finishes, then one DMASR poll window, write 0x00=0, IDLE,
//    running=0.
//  6 VDMA_TIMEOUT_EN, awready held low -> abort at 4096 cycles, dma_error=1; rst mid-write ->
//    all valids 0 next edge.

Source files
------------

// File: rtl/vdma_cfg_pkg.sv
// vdma_cfg_pkg: sequencer state codes, VDMA register offsets and control words.
// Optional watchdog in the bus engine is enabled by defining VDMA_TIMEOUT_EN.
package vdma_cfg_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SRST  = 3'd1;
    localparam logic [2:0] ST_WAITR = 3'd2;
    localparam logic [2:0] ST_CFG   = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_ERR   = 3'd5;
    localparam logic [2:0] ST_HALT  = 3'd6;

    localparam logic [7:0] OFF_DMACR      = 8'h00;
    localparam logic [7:0] OFF_DMASR      = 8'h04;
    localparam logic [7:0] OFF_VSIZE      = 8'h50;
    localparam logic [7:0] OFF_HSIZE      = 8'h54;
    localparam logic [7:0] OFF_STRIDE     = 8'h58;
    localparam logic [7:0] OFF_START_ADDR = 8'h5C;

    localparam logic [31:0] DMACR_RUN   = 32'h0000_0003;
    localparam logic [31:0] DMACR_RESET = 32'h0000_0004;
    localparam logic [31:0] DMACR_HALT  = 32'h0000_0000;
    localparam logic [31:0] ERR_MASK    = 32'h0000_4FF0;
endpackage

// File: rtl/axil_single_master.sv
// axil_single_master: one-outstanding AXI4-Lite read/write engine.
// Transaction watchdog is active only when VDMA_TIMEOUT_EN is defined.
module axil_single_master #(
    parameter int A              = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic         we,
    input  logic [A-1:0] addr,
    input  logic [31:0]  wdata,
    output logic         done,
    output logic [31:0]  rdata,
    output logic         err,
    output logic         timeout,
    output logic [A-1:0] m_axi_awaddr,
    output logic         m_axi_awvalid,
    input  logic         m_axi_awready,
    output logic [31:0]  m_axi_wdata,
    output logic [3:0]   m_axi_wstrb,
    output logic         m_axi_wvalid,
    input  logic         m_axi_wready,
    input  logic [1:0]   m_axi_bresp,
    input  logic         m_axi_bvalid,
    output logic         m_axi_bready,
    output logic [A-1:0] m_axi_araddr,
    output logic         m_axi_arvalid,
    input  logic         m_axi_arready,
    input  logic [31:0]  m_axi_rdata,
    input  logic [1:0]   m_axi_rresp,
    input  logic         m_axi_rvalid,
    output logic         m_axi_rready
);
    // Handshakes: every valid/ready output is a flop, raised only when the engine is idle and
    // dropped on its own valid&ready edge; bready/rready stay high until the response arrives.
`ifdef VDMA_TIMEOUT_EN
    localparam logic WD_EN = 1'b1;
`else
    localparam logic WD_EN = 1'b0;
`endif

    logic        active;
    logic        expired;
    logic [31:0] wd_cnt;

    assign m_axi_wstrb = 4'hF;
    assign active  = m_axi_awvalid | m_axi_wvalid | m_axi_bready | m_axi_arvalid | m_axi_rready;
    assign expired = WD_EN && active && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            timeout       <= 1'b0;
            rdata         <= '0;
            wd_cnt        <= '0;
        end else begin
            done    <= 1'b0;
            err     <= 1'b0;
            timeout <= 1'b0;
            wd_cnt  <= active ? wd_cnt + 32'd1 : 32'd0;
            if (req && !active) begin
                if (we) begin
                    m_axi_awaddr  <= addr;
                    m_axi_wdata   <= wdata;
                    m_axi_awvalid <= 1'b1;
                    m_axi_wvalid  <= 1'b1;
                    m_axi_bready  <= 1'b1;
                end else begin
                    m_axi_araddr  <= addr;
                    m_axi_arvalid <= 1'b1;
                end
            end
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if (m_axi_bready && m_axi_bvalid) begin
                m_axi_bready <= 1'b0;
                done         <= 1'b1;
                err          <= (m_axi_bresp != 2'b00);
            end
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b1;
            end
            if (m_axi_rready && m_axi_rvalid) begin
                m_axi_rready <= 1'b0;
                rdata        <= m_axi_rdata;
                done         <= 1'b1;
                err          <= (m_axi_rresp != 2'b00);
            end
            // Abort wins over a same-cycle response; a late response later meets a low ready.
            if (expired) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                done          <= 1'b1;
                err           <= 1'b1;
                timeout       <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/vdma_cfg_sequencer.sv
// vdma_cfg_sequencer: brings up the VDMA MM2S channel over AXI4-Lite, polls status, recovers on error.
// Define VDMA_TIMEOUT_EN to enable the per-transaction watchdog in the bus engine.
module vdma_cfg_sequencer
    import vdma_cfg_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] VDMA_BASEADDR      = 32'h4300_0000,
    parameter logic [31:0] FB_BASEADDR        = 32'h1000_0000,
    parameter int          VID_H_ACTIVE       = 1280,
    parameter int          VID_V_ACTIVE       = 720,
    parameter int          BYTES_PER_PIXEL    = 3,
    parameter int          NUM_FRAMES         = 3,
    parameter int          POLL_INTERVAL      = 1024,
    parameter int          TIMEOUT_CYCLES     = 4096
) (
    input  logic                          ps_clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
    output logic [3:0]                    m_axi_wstrb,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic                          busy,
    output logic                          running,
    output logic                          dma_error,
    output logic [7:0]                    err_count,
    output logic [2:0]                    state_dbg
);
    localparam logic [31:0] HSIZE       = 32'(VID_H_ACTIVE * BYTES_PER_PIXEL);
    localparam logic [31:0] VSIZE       = 32'(VID_V_ACTIVE);
    localparam logic [31:0] FRAME_BYTES = HSIZE * VSIZE;
    localparam logic [3:0]  LAST_IDX    = 4'(NUM_FRAMES + 3);

    logic [2:0]  state;
    logic [3:0]  idx;
    logic [3:0]  fidx;
    logic [31:0] fb_addr;
    logic [31:0] poll_cnt;
    logic        pending;
    logic        stop_pend;
    logic        need, req, we;
    logic [7:0]  off;
    logic [31:0] req_wdata;
    logic        done, err, timeout;
    logic [31:0] rdata;

    assign busy      = (state != ST_IDLE) && (state != ST_RUN);
    assign running   = (state == ST_RUN);
    assign state_dbg = state;
    assign fidx      = idx - 4'd1;

    // CFG table: idx 0 = DMACR, 1..NUM_FRAMES = START_ADDR, then STRIDE, HSIZE, VSIZE.
    always_comb begin
        need      = 1'b0;
        we        = 1'b1;
        off       = OFF_DMACR;
        req_wdata = DMACR_HALT;
        case (state)
            ST_SRST: begin need = 1'b1; req_wdata = DMACR_RESET; end
            ST_WAITR: begin need = 1'b1; we = 1'b0; end
            ST_CFG: begin
                need = 1'b1;
                if (idx == 4'd0) begin
                    req_wdata = DMACR_RUN;
                end else if (idx <= 4'(NUM_FRAMES)) begin
                    off       = OFF_START_ADDR + {2'b00, fidx, 2'b00};
                    req_wdata = fb_addr;
                end else if (idx == 4'(NUM_FRAMES + 1)) begin
                    off = OFF_STRIDE; req_wdata = HSIZE;
                end else if (idx == 4'(NUM_FRAMES + 2)) begin
                    off = OFF_HSIZE; req_wdata = HSIZE;
                end else begin
                    off = OFF_VSIZE; req_wdata = VSIZE;
                end
            end
            ST_RUN: begin
                need = (poll_cnt == 32'(POLL_INTERVAL - 1));
                we   = 1'b0;
                off  = OFF_DMASR;
            end
            ST_ERR: begin need = 1'b1; off = OFF_DMASR; req_wdata = ERR_MASK; end
            ST_HALT: need = 1'b1;
            default: need = 1'b0;
        endcase
        req = need && !pending;
    end

    always_ff @(posedge ps_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            fb_addr   <= FB_BASEADDR;
            poll_cnt  <= '0;
            pending   <= 1'b0;
            stop_pend <= 1'b0;
            dma_error <= 1'b0;
            err_count <= '0;
        end else begin
            if (req) pending <= 1'b1;
            if (stop && state != ST_IDLE) stop_pend <= 1'b1;
            if (state == ST_IDLE && start) begin
                state     <= ST_SRST;
                stop_pend <= stop;
                dma_error <= 1'b0;
                err_count <= '0;
            end
            if (state == ST_RUN && !pending && poll_cnt != 32'(POLL_INTERVAL - 1))
                poll_cnt <= poll_cnt + 32'd1;
            if (done) begin
                pending <= 1'b0;
                if (timeout) begin
                    dma_error <= 1'b1;
                    state     <= ST_SRST;
                end else if (err || (state == ST_RUN && |(rdata & ERR_MASK))) begin
                    // A failure while clearing status goes straight to reset, counted once.
                    if (state == ST_ERR) begin
                        state <= ST_SRST;
                    end else begin
                        state     <= ST_ERR;
                        dma_error <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end
                end else begin
                    case (state)
                        ST_SRST: state <= ST_WAITR;
                        ST_WAITR: if (!rdata[2]) begin
                            state   <= ST_CFG;
                            idx     <= '0;
                            fb_addr <= FB_BASEADDR;
                        end
                        ST_CFG: begin
                            if (idx != 4'd0 && idx <= 4'(NUM_FRAMES)) fb_addr <= fb_addr + FRAME_BYTES;
                            if (idx == LAST_IDX) begin
                                state    <= ST_RUN;
                                poll_cnt <= '0;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                        ST_RUN: begin
                            poll_cnt <= '0;
                            if (stop_pend) state <= ST_HALT;
                        end
                        ST_ERR: state <= ST_SRST;
                        ST_HALT: begin
                            state     <= ST_IDLE;
                            stop_pend <= 1'b0;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    axil_single_master #(
        .A              (C_M_AXI_ADDR_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus (
        .clk           (ps_clk),
        .rst           (rst),
        .req           (req),
        .we            (we),
        .addr          (C_M_AXI_ADDR_WIDTH'(VDMA_BASEADDR + {24'd0, off})),
        .wdata         (req_wdata),
        .done          (done),
        .rdata         (rdata),
        .err           (err),
        .timeout       (timeout),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );
endmodule

// File: tb/tb_vdma_cfg_sequencer.sv
// tb_vdma_cfg_sequencer: randomized AXI4-Lite slave, transaction scoreboard and scenario driver.
// Define VDMA_TIMEOUT_EN to also exercise the watchdog abort.
module tb_vdma_cfg_sequencer;
    import vdma_cfg_pkg::*;

    localparam logic [31:0] BASE  = 32'h4300_0000;
    localparam logic [31:0] FB    = 32'h1000_0000;
    localparam int          H_ACT = 1280;
    localparam int          V_ACT = 720;
    localparam int          BPP   = 3;
    localparam int          NFR   = 3;

    logic        ps_clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [31:0] m_axi_rdata = '0;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_arready = 1'b0;
    logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic        busy, running, dma_error;
    logic [7:0]  err_count;
    logic [2:0]  state_dbg;

    int          checks = 0, errors = 0;
    logic [64:0] exp_q[$];
    logic [64:0] act_q[$];

    int          skew_max = 0;
    bit          hold_aw = 1'b0;
    int          reset_polls_cfg = 0;
    logic [31:0] dmasr_val = '0;
    logic [31:0] bad_addr = '0;
    bit          bad_armed = 1'b0;

    vdma_cfg_sequencer dut (
        .ps_clk(ps_clk), .rst(rst), .start(start), .stop(stop),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .busy(busy), .running(running),
        .dma_error(dma_error), .err_count(err_count), .state_dbg(state_dbg)
    );

    always #5 ps_clk = ~ps_clk;

    // Reference model: the register traffic each phase must produce.
    function automatic void push_w(input logic [31:0] off, input logic [31:0] data);
        exp_q.push_back({1'b1, BASE + off, data});
    endfunction
    function automatic void push_r(input logic [31:0] off);
        exp_q.push_back({1'b0, BASE + off, 32'd0});
    endfunction
    function automatic void push_bringup(input int polls, input bit cut_after_hsize);
        push_w(32'h00, 32'h4);
        for (int i = 0; i <= polls; i++) push_r(32'h00);
        push_w(32'h00, 32'h3);
        for (int n = 0; n < NFR; n++)
            push_w(32'h5C + 32'(4 * n), FB + 32'(n) * 32'(H_ACT * BPP) * 32'(V_ACT));
        push_w(32'h58, 32'(H_ACT * BPP));
        push_w(32'h54, 32'(H_ACT * BPP));
        if (!cut_after_hsize) push_w(32'h50, 32'(V_ACT));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic bit cond(input int what);
        case (what)
            0: return running;
            1: return !running && !busy;
            2: return state_dbg == ST_CFG;
            3: return running && err_count == 8'd1;
            4: return m_axi_awvalid;
            5: return dma_error;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string name, output int n);
        n = 0;
        while (!cond(what) && n < budget) begin
            @(negedge ps_clk);
            n++;
        end
        checks++;
        if (!cond(what)) begin
            errors++;
            $display("FAIL %s: condition not reached, got timeout expected within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse(input bit do_start, input bit do_stop);
        @(negedge ps_clk);
        start = do_start;
        stop  = do_stop;
        @(negedge ps_clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Slave: values seen at one negedge are what the DUT held at the following posedge.
    initial begin : slave
        logic        s_awv, s_wv, s_br, s_arv, s_rr;
        logic [31:0] s_awa, s_wd, s_ara, aw_a, w_d, r_a;
        bit          aw_have, w_have, r_pend;
        int          aw_wait, w_wait, ar_wait, polls_left;
        s_awv = 0; s_wv = 0; s_br = 0; s_arv = 0; s_rr = 0;
        s_awa = 0; s_wd = 0; s_ara = 0; aw_a = 0; w_d = 0; r_a = 0;
        aw_have = 0; w_have = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; polls_left = 0;
        forever begin
            @(negedge ps_clk);
            if (rst) begin
                aw_have = 0; w_have = 0; r_pend = 0; polls_left = 0;
                s_awv = 0; s_wv = 0; s_br = 0; s_arv = 0; s_rr = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                continue;
            end
            if (s_awv && m_axi_awready) begin
                aw_have = 1; aw_a = s_awa; aw_wait = $urandom_range(0, skew_max);
            end
            if (s_wv && m_axi_wready) begin
                w_have = 1; w_d = s_wd; w_wait = $urandom_range(0, skew_max);
            end
            if (s_br && m_axi_bvalid) m_axi_bvalid = 0;
            if (s_arv && m_axi_arready) begin
                r_pend = 1; r_a = s_ara; ar_wait = $urandom_range(0, skew_max);
            end
            if (s_rr && m_axi_rvalid) m_axi_rvalid = 0;
            if (aw_have && w_have) begin
                act_q.push_back({1'b1, aw_a, w_d});
                if (aw_a == BASE && w_d[2]) polls_left = reset_polls_cfg;
                if (aw_a == BASE + 32'h4) dmasr_val = dmasr_val & ~w_d;
                m_axi_bresp = 2'b00;
                if (bad_armed && aw_a == bad_addr) begin
                    m_axi_bresp = 2'b10;
                    bad_armed = 0;
                end
                m_axi_bvalid = 1; aw_have = 0; w_have = 0;
            end
            if (r_pend) begin
                act_q.push_back({1'b0, r_a, 32'd0});
                m_axi_rdata = 32'd0;
                if (r_a == BASE && polls_left > 0) begin
                    m_axi_rdata = 32'h4; polls_left--;
                end else if (r_a == BASE + 32'h4) begin
                    m_axi_rdata = dmasr_val;
                end
                m_axi_rresp = 2'b00; m_axi_rvalid = 1; r_pend = 0;
            end
            m_axi_awready = 0;
            if (m_axi_awvalid && !aw_have && !hold_aw) begin
                if (aw_wait > 0) aw_wait--; else m_axi_awready = 1;
            end
            m_axi_wready = 0;
            if (m_axi_wvalid && !w_have) begin
                if (w_wait > 0) w_wait--; else m_axi_wready = 1;
            end
            m_axi_arready = 0;
            if (m_axi_arvalid && !r_pend) begin
                if (ar_wait > 0) ar_wait--; else m_axi_arready = 1;
            end
            s_awv = m_axi_awvalid; s_awa = m_axi_awaddr;
            s_wv = m_axi_wvalid; s_wd = m_axi_wdata;
            s_br = m_axi_bready; s_arv = m_axi_arvalid; s_ara = m_axi_araddr; s_rr = m_axi_rready;
        end
    end

    initial begin : monitor
        logic [64:0] act, want;
        forever begin
            @(negedge ps_clk);
            while (act_q.size() > 0) begin
                act = act_q.pop_front();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn: got we=%0b addr=%h data=%h expected no transaction",
                             act[64], act[63:32], act[31:0]);
                end else begin
                    want = exp_q.pop_front();
                    if (act !== want) begin
                        errors++;
                        $display("FAIL txn: got we=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                                 act[64], act[63:32], act[31:0], want[64], want[63:32], want[31:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900_000;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $fatal(1, "global timeout");
    end

    initial begin : main
        int n, mode;
        repeat (3) @(negedge ps_clk);
        check("reset_busy", busy, 0);
        check("reset_running", running, 0);
        check("reset_dma_error", dma_error, 0);
        check("reset_err_count", err_count, 0);
        check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("reset_readies", {m_axi_bready, m_axi_rready}, 0);
        rst = 1'b0;
        repeat (2) @(negedge ps_clk);
        check("idle_no_traffic", {m_axi_awvalid, m_axi_arvalid}, 0);

        // Bring-up and halt: zero-wait first, then skewed slaves and varied stop timing.
        for (int it = 0; it < 5; it++) begin
            mode            = (it == 0) ? 0 : int'($urandom_range(0, 2));
            skew_max        = (it == 0) ? 0 : 5;
            reset_polls_cfg = (it == 0) ? 0 : int'($urandom_range(0, 3));
            push_bringup(reset_polls_cfg, 1'b0);
            push_r(32'h04);
            push_w(32'h00, 32'h0);
            pulse(1'b1, mode == 2);
            check("busy_after_start", busy, 1);
            if (mode == 1) begin
                wait_for(2, 500, "reach_cfg", n);
                pulse(1'b0, 1'b1);
            end
            wait_for(0, 2000, "reach_run", n);
            check("run_busy", busy, 0);
            check("run_dma_error", dma_error, 0);
            check("run_err_count", err_count, 0);
            if (mode == 0) pulse(1'b0, 1'b1);
            wait_for(1, 3000, "reach_idle", n);
            repeat (3) @(negedge ps_clk);
            check("halt_running", running, 0);
            check("halt_exp_drained", exp_q.size(), 0);
        end

        // DMASR error in RUN: clear, count, reprogram.
        skew_max = 3; reset_polls_cfg = 1; dmasr_val = 32'h0000_0010;
        push_bringup(1, 1'b0); push_r(32'h04); push_w(32'h04, 32'h4FF0); push_bringup(1, 1'b0);
        pulse(1'b1, 1'b0);
        wait_for(3, 5000, "dmasr_recover", n);
        check("dmasr_err_count", err_count, 1);
        check("dmasr_dma_error", dma_error, 1);
        push_r(32'h04); push_w(32'h00, 32'h0);
        pulse(1'b0, 1'b1);
        wait_for(1, 3000, "dmasr_idle", n);
        check("dmasr_error_sticky", dma_error, 1);

        // Bad bresp on HSIZE write, then a fresh start clears the counters.
        reset_polls_cfg = 0; bad_addr = BASE + 32'h54; bad_armed = 1'b1;
        push_bringup(0, 1'b1); push_w(32'h04, 32'h4FF0); push_bringup(0, 1'b0);
        pulse(1'b1, 1'b0);
        wait_for(3, 5000, "bresp_recover", n);
        check("bresp_dma_error", dma_error, 1);
        push_r(32'h04); push_w(32'h00, 32'h0);
        pulse(1'b0, 1'b1);
        wait_for(1, 3000, "bresp_idle", n);
        check("bresp_err_count_idle", err_count, 1);
        push_bringup(0, 1'b0); push_r(32'h04); push_w(32'h00, 32'h0);
        pulse(1'b1, 1'b0);
        check("start_clears_err_count", err_count, 0);
        check("start_clears_dma_error", dma_error, 0);
        pulse(1'b0, 1'b1);
        wait_for(1, 3000, "restart_idle", n);
        repeat (3) @(negedge ps_clk);
        check("restart_exp_drained", exp_q.size(), 0);

        // Reset while a write is open.
        hold_aw = 1'b1;
        pulse(1'b1, 1'b0);
        wait_for(4, 50, "aw_open", n);
        repeat (3) @(negedge ps_clk);
        check("aw_held_open", m_axi_awvalid, 1);
        rst = 1'b1;
        @(negedge ps_clk);
        check("rst_drops_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("rst_drops_readies", {m_axi_bready, m_axi_rready}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0; hold_aw = 1'b0;
        @(negedge ps_clk);
        exp_q.delete(); act_q.delete();

`ifdef VDMA_TIMEOUT_EN
        // Watchdog: awready held low until the engine gives up.
        hold_aw = 1'b1;
        pulse(1'b1, 1'b0);
        wait_for(4, 50, "to_aw_open", n);
        wait_for(5, 5000, "to_abort", n);
        check("to_cycles_window", (n >= 4090 && n <= 4100), 1);
        check("to_aw_dropped", m_axi_awvalid, 0);
        rst = 1'b1;
        @(negedge ps_clk);
        check("to_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        rst = 1'b0; hold_aw = 1'b0;
        @(negedge ps_clk);
        exp_q.delete(); act_q.delete();
`endif

        repeat (5) @(negedge ps_clk);
        check("final_exp_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
